// File: rtl/game_ctrl_pkg.sv
// Shared types and helpers for the game move sequencer.
package game_ctrl_pkg;

    // Move codes as presented by the requester.
    typedef enum logic [1:0] {
        DIR_N = 2'b00,
        DIR_S = 2'b01,
        DIR_E = 2'b10,
        DIR_W = 2'b11
    } dir_t;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        IDLE,
        RST_CORE,
        PLAY,
        ISSUE,
        SETTLE,
        DONE
    } seq_state_t;

    // Number of cycles the game core is held in reset before play begins.
    localparam int CORE_RST_CYCLES = 2;

    // Decode a move code into the core's one-hot strobe, packed as {n,s,e,w}.
    function automatic logic [3:0] dir_onehot(input dir_t d);
        logic [3:0] oh;
        oh = 4'b0000;
        case (d)
            DIR_N:   oh = 4'b1000;
            DIR_S:   oh = 4'b0100;
            DIR_E:   oh = 4'b0010;
            DIR_W:   oh = 4'b0001;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Small synchronous FIFO holding pending move codes. The pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module move_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A full queue refuses a push even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush discards everything and wins over push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/game_move_sequencer.sv
// Sequences queued moves into the adventure-game core: one-hot pulse per move,
// settle window, then sample win/die and latch the game result.
//
// Move handshake: a move is transferred on a rising clk edge where
// mv_valid && mv_ready are both high; the requester must hold mv_valid and
// mv_dir stable until that edge, and mv_ready never depends on mv_valid.
module game_move_sequencer
    import game_ctrl_pkg::*;
#(
    parameter  int DEPTH     = 8,
    parameter  int SETTLE    = 1,
    parameter  int MAX_MOVES = 200,
    parameter  int COUNT_W   = 8,
    localparam int QW        = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mv_valid,
    input  logic [1:0]         mv_dir,
    output logic               mv_ready,
    output logic               core_reset,
    output logic               core_n,
    output logic               core_s,
    output logic               core_e,
    output logic               core_w,
    input  logic               core_win,
    input  logic               core_die,
    output logic               busy,
    output logic               done,
    output logic               result_win,
    output logic               result_die,
    output logic               result_timeout,
    output logic [COUNT_W-1:0] move_count,
    output seq_state_t         fsm_state,
    output logic [QW-1:0]      queue_count
);

    localparam int TMR_MAX = (CORE_RST_CYCLES > SETTLE) ? CORE_RST_CYCLES : SETTLE;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0]   RST_LAST    = TMR_W'(CORE_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]   SETTLE_LAST = TMR_W'(SETTLE - 1);
    localparam logic [COUNT_W-1:0] MAX_CNT     = COUNT_W'(MAX_MOVES);

    seq_state_t       state;
    seq_state_t       next_state;
    logic [TMR_W-1:0] tmr;
    logic             restart;
    logic             timer_load;
    logic             do_pop;
    logic             do_push;
    logic             flush;
    logic             end_win;
    logic             end_die;
    logic             end_timeout;
    logic             q_full;
    logic             q_empty;
    logic [1:0]       q_dout;

    // A start outside IDLE aborts whatever the game is doing.
    assign restart    = start && (state != IDLE);
    assign timer_load = (next_state != state) || restart;
    assign mv_ready   = reset && (state != DONE) && !q_full && !start;
    assign do_push    = mv_valid && mv_ready;
    // Queue is emptied on abort and on the way into DONE.
    assign flush      = restart || ((next_state == DONE) && (state != DONE));
    assign fsm_state  = state;

    move_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (do_push),
        .din   (mv_dir),
        .pop   (do_pop),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (queue_count)
    );

    // Next-state logic; the abort override is applied last so it wins.
    always_comb begin
        next_state  = state;
        do_pop      = 1'b0;
        end_win     = 1'b0;
        end_die     = 1'b0;
        end_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = RST_CORE;
            end
            RST_CORE: begin
                if (tmr == RST_LAST) next_state = PLAY;
            end
            PLAY: begin
                if (!q_empty) begin
                    next_state = ISSUE;
                    do_pop     = 1'b1;
                end
            end
            ISSUE: begin
                next_state = game_ctrl_pkg::SETTLE;
            end
            game_ctrl_pkg::SETTLE: begin
                if (tmr == SETTLE_LAST) begin
                    if (core_die) begin
                        next_state = DONE;
                        end_die    = 1'b1;
                    end else if (core_win) begin
                        next_state = DONE;
                        end_win    = 1'b1;
                    end else if (move_count == MAX_CNT) begin
                        next_state  = DONE;
                        end_timeout = 1'b1;
                    end else begin
                        next_state = PLAY;
                    end
                end
            end
            DONE: begin
                next_state = DONE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (restart) begin
            next_state  = RST_CORE;
            do_pop      = 1'b0;
            end_win     = 1'b0;
            end_die     = 1'b0;
            end_timeout = 1'b0;
        end
    end

    // State register and cycle timer shared by the reset and settle windows.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            tmr   <= '0;
        end else begin
            state <= next_state;
            if (timer_load) tmr <= '0;
            else if ((state == RST_CORE) || (state == game_ctrl_pkg::SETTLE)) tmr <= tmr + 1'b1;
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_reset                      <= 1'b1;
            {core_n, core_s, core_e, core_w} <= 4'b0000;
            busy                            <= 1'b0;
            done                            <= 1'b0;
        end else begin
            core_reset <= (next_state == IDLE) || (next_state == RST_CORE);
            busy       <= (next_state == RST_CORE) || (next_state == PLAY) ||
                          (next_state == ISSUE) || (next_state == game_ctrl_pkg::SETTLE);
            done       <= (next_state == DONE);
            if (next_state == ISSUE) {core_n, core_s, core_e, core_w} <= dir_onehot(dir_t'(q_dout));
            else                     {core_n, core_s, core_e, core_w} <= 4'b0000;
        end
    end

    // Move counter and result latches; cleared by an abort, held through DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            move_count     <= '0;
            result_win     <= 1'b0;
            result_die     <= 1'b0;
            result_timeout <= 1'b0;
        end else if (restart) begin
            move_count     <= '0;
            result_win     <= 1'b0;
            result_die     <= 1'b0;
            result_timeout <= 1'b0;
        end else begin
            if ((next_state == ISSUE) && (move_count != MAX_CNT)) move_count <= move_count + 1'b1;
            if (end_win)     result_win     <= 1'b1;
            if (end_die)     result_die     <= 1'b1;
            if (end_timeout) result_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_game_move_sequencer.sv
// Bench for game_move_sequencer: a behavioural game-core stand-in, a scoreboard
// of expected pulses and game results, directed scenarios and random games.
module tb_game_move_sequencer;
    import game_ctrl_pkg::*;

    localparam int DEPTH      = 8;
    localparam int SETTLE_CYC = 1;
    localparam int MAX_MV     = 5;
    localparam int COUNT_W    = 8;
    localparam int QW         = $clog2(DEPTH) + 1;
    localparam int W          = 16;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               mv_valid;
    logic [1:0]         mv_dir;
    logic               mv_ready;
    logic               core_reset;
    logic               core_n, core_s, core_e, core_w;
    logic               core_win = 1'b0;
    logic               core_die = 1'b0;
    logic               busy, done;
    logic               result_win, result_die, result_timeout;
    logic [COUNT_W-1:0] move_count;
    seq_state_t         fsm_state;
    logic [QW-1:0]      queue_count;

    game_move_sequencer #(
        .DEPTH     (DEPTH),
        .SETTLE    (SETTLE_CYC),
        .MAX_MOVES (MAX_MV),
        .COUNT_W   (COUNT_W)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .start          (start),
        .mv_valid       (mv_valid),
        .mv_dir         (mv_dir),
        .mv_ready       (mv_ready),
        .core_reset     (core_reset),
        .core_n         (core_n),
        .core_s         (core_s),
        .core_e         (core_e),
        .core_w         (core_w),
        .core_win       (core_win),
        .core_die       (core_die),
        .busy           (busy),
        .done           (done),
        .result_win     (result_win),
        .result_die     (result_die),
        .result_timeout (result_timeout),
        .move_count     (move_count),
        .fsm_state      (fsm_state),
        .queue_count    (queue_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- game core stand-in ----------------
    // Counts move pulses since its reset; die/win rise after the chosen move.
    int hits   = 0;
    int die_at = 99;
    int win_at = 99;
    always @(posedge clk) begin
        if (core_reset) begin
            hits     <= 0;
            core_win <= 1'b0;
            core_die <= 1'b0;
        end else if (core_n | core_s | core_e | core_w) begin
            hits     <= hits + 1;
            core_die <= (hits + 1 >= die_at);
            core_win <= (hits + 1 >= win_at);
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           pulse_t[$];
    int           mv_list[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_onehot(input int code);
        logic [3:0] base;
        base = 4'b1000;
        return base >> code;
    endfunction

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return m;
    endfunction

    // Reference model: a game issues moves in acceptance order until the first
    // of die, win or the move limit; die beats win when both hit together.
    task automatic expect_game(input int d_at, input int w_at);
        int e;
        int k;
        logic [2:0] res;
        e = min3(d_at, w_at, MAX_MV);
        k = (mv_list.size() < e) ? mv_list.size() : e;
        for (int i = 0; i < k; i++)
            exp_q.push_back({2'b01, 2'b00, model_onehot(mv_list[i]), 8'(i + 1)});
        if (mv_list.size() >= e) begin
            if (d_at == e)      res = 3'b010;
            else if (w_at == e) res = 3'b100;
            else                res = 3'b001;
            exp_q.push_back({2'b10, 3'b000, res, 8'(e)});
        end
    endtask

    // Monitor: pops an expectation whenever a pulse or a game end appears.
    logic         done_q = 1'b0;
    logic [W-1:0] mon_item;
    always @(negedge clk) begin
        if (rst_n) begin
            if (core_n | core_s | core_e | core_w) begin
                pulse_t.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {core_n, core_s, core_e, core_w}, 0);
                end else begin
                    mon_item = exp_q.pop_front();
                    check("pulse", {2'b01, 2'b00, core_n, core_s, core_e, core_w, move_count}, mon_item);
                end
            end
            if (done && !done_q) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    mon_item = exp_q.pop_front();
                    check("game_end", {2'b10, 3'b000, result_win, result_die, result_timeout, move_count}, mon_item);
                end
            end
        end
        done_q <= done;
    end

    // ---------------- driver tasks ----------------
    task automatic push_move(input int code, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            mv_valid = 1'b1;
            mv_dir   = 2'(code);
            #1;
            if (mv_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        mv_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_game(input int d_at, input int w_at);
        bit ok;
        die_at = d_at;
        win_at = w_at;
        expect_game(d_at, w_at);
        pulse_start();
        foreach (mv_list[i]) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push_move(mv_list[i], ok);
            if (!ok) break;
        end
        wait_drain();
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        int e;
        rst_n    = 1'b0;
        start    = 1'b0;
        mv_valid = 1'b0;
        mv_dir   = 2'b00;
        repeat (3) @(negedge clk);

        // reset values
        check("rst_state", fsm_state, 32'(IDLE));
        check("rst_core_reset", core_reset, 1);
        check("rst_dirs", {core_n, core_s, core_e, core_w}, 0);
        check("rst_mv_ready", mv_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_results", {result_win, result_die, result_timeout}, 0);
        check("rst_count", move_count, 0);
        check("rst_queue", queue_count, 0);
        rst_n = 1'b1;

        // Game A: fill the queue in IDLE, 9th move held, then timeout at 5 moves
        mv_list = '{0, 2, 1, 3};
        for (int i = 0; i < 5; i++) mv_list.push_back(int'($urandom_range(0, 3)));
        die_at = 99;
        win_at = 99;
        expect_game(99, 99);
        pulse_t.delete();
        for (int i = 0; i < 8; i++) begin
            push_move(mv_list[i], ok);
            check("fill_accept", ok, 1);
        end
        @(negedge clk);
        mv_valid = 1'b1;
        mv_dir   = 2'(mv_list[8]);
        #1;
        check("full_ready", mv_ready, 0);
        check("full_count", queue_count, 8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rc_state", fsm_state, 32'(RST_CORE));
        check("rc_core_reset1", core_reset, 1);
        check("rc_busy", busy, 1);
        check("rc_done", done, 0);
        check("rc_count", move_count, 0);
        @(negedge clk);
        check("rc_core_reset2", core_reset, 1);
        @(negedge clk);
        check("play_core_reset", core_reset, 0);
        check("play_state", fsm_state, 32'(PLAY));
        check("play_full_ready", mv_ready, 0);
        @(negedge clk);
        check("pop_ready", mv_ready, 1);
        check("first_pulse_n", core_n, 1);
        @(posedge clk);
        #1;
        mv_valid = 1'b0;
        @(negedge clk);
        check("ninth_accepted", queue_count, 8);
        wait_drain();
        @(negedge clk);
        check("to_done", done, 1);
        check("to_result", result_timeout, 1);
        check("to_busy", busy, 0);
        check("to_queue_flushed", queue_count, 0);
        check("to_ready", mv_ready, 0);
        check("pulse_total", pulse_t.size(), 5);
        for (int i = 1; i < pulse_t.size(); i++)
            check("pulse_spacing", pulse_t[i] - pulse_t[i-1], 2 + SETTLE_CYC);

        // Game B: N,E,S,W without a result -> four moves, back in PLAY
        mv_list = '{0, 2, 1, 3};
        run_game(99, 99);
        repeat (2) @(negedge clk);
        check("nesw_state", fsm_state, 32'(PLAY));
        check("nesw_count", move_count, 4);
        check("nesw_done", done, 0);

        // Game C: die on move 3
        mv_list.delete();
        for (int i = 0; i < 5; i++) mv_list.push_back(int'($urandom_range(0, 3)));
        run_game(3, 99);
        check("die_done", done, 1);
        check("die_result", result_die, 1);
        check("die_count", move_count, 3);
        check("die_queue", queue_count, 0);
        check("die_ready", mv_ready, 0);

        // Game D: win and die together -> die wins
        mv_list.delete();
        for (int i = 0; i < 4; i++) mv_list.push_back(int'($urandom_range(0, 3)));
        run_game(2, 2);
        check("both_die", result_die, 1);
        check("both_win", result_win, 0);

        // Asynchronous reset away from any clock edge
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", fsm_state, 32'(IDLE));
        check("arst_done", done, 0);
        check("arst_results", {result_win, result_die, result_timeout}, 0);
        check("arst_core_reset", core_reset, 1);
        check("arst_count", move_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Game E: abort with start during ISSUE while 3 moves are queued
        mv_list.delete();
        for (int i = 0; i < 4; i++) mv_list.push_back(int'($urandom_range(0, 3)));
        die_at = 99;
        win_at = 99;
        exp_q.push_back({2'b01, 2'b00, model_onehot(mv_list[0]), 8'd1});
        for (int i = 0; i < 4; i++) push_move(mv_list[i], ok);
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (core_n | core_s | core_e | core_w) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_pulse_seen", ok, 1);
        check("abort_queued", queue_count, 3);
        #1;
        start    = 1'b1;
        mv_valid = 1'b1;
        mv_dir   = 2'($urandom_range(0, 3));
        @(negedge clk);
        check("abort_dirs", {core_n, core_s, core_e, core_w}, 0);
        check("abort_queue", queue_count, 0);
        check("abort_count", move_count, 0);
        check("abort_state", fsm_state, 32'(RST_CORE));
        start    = 1'b0;
        mv_valid = 1'b0;
        wait_drain();

        // Random games
        for (int g = 0; g < 10; g++) begin
            int d;
            int w;
            mv_list.delete();
            for (int i = 0; i < int'($urandom_range(1, 7)); i++)
                mv_list.push_back(int'($urandom_range(0, 3)));
            d = int'($urandom_range(1, 8));
            w = int'($urandom_range(1, 8));
            e = min3(d, w, MAX_MV);
            run_game(d, w);
            if (mv_list.size() >= e) check("rand_done", done, 1);
            else                     check("rand_play", fsm_state, 32'(PLAY));
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
